// File: rtl/decode_stage_controller_pkg.sv
// Shared opcode constants, pipeline-entry type and operand-usage helpers for
// the decode stage.
package decode_stage_controller_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // Stored PC width; the stage casts to and from XLEN at its boundary.
   localparam int unsigned PIPE_PC_W = 32;

   typedef struct packed {
      logic                 valid;
      logic [PIPE_PC_W-1:0] pc;
      logic [31:0]          instr;
   } pipe_entry_t;

   function automatic logic rs1_is_read(input logic [6:0] op);
      return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
   endfunction

   function automatic logic rs2_is_read(input logic [6:0] op);
      return op inside {OP_REG, OP_STORE, OP_BRANCH};
   endfunction

endpackage

// File: rtl/decode_stage_controller_if.sv
// Fetch / execute / hazard-feedback signal bundle of the decode stage.
// master: the surrounding pipeline (fetch, execute); slave: the decode stage.
interface decode_stage_controller_if #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned STALL_CNT_W = 32
);
   logic                   in_valid;
   logic                   in_ready;
   logic [XLEN-1:0]        in_pc;
   logic [31:0]            in_instr;
   logic                   flush;
   logic                   ex_load_valid;
   logic [4:0]             ex_load_rd;
   logic                   out_valid;
   logic                   out_ready;
   logic [XLEN-1:0]        out_pc;
   logic [31:0]            out_instr;
   logic [XLEN-1:0]        out_imm;
   logic [4:0]             out_rs1;
   logic [4:0]             out_rs2;
   logic [4:0]             out_rd;
   logic                   out_rs1_used;
   logic                   out_rs2_used;
   logic                   hazard;
   logic [STALL_CNT_W-1:0] stall_cycles;

   modport master (
      output in_valid, in_pc, in_instr, flush, ex_load_valid, ex_load_rd, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_imm, out_rs1, out_rs2, out_rd,
             out_rs1_used, out_rs2_used, hazard, stall_cycles
   );

   modport slave (
      input  in_valid, in_pc, in_instr, flush, ex_load_valid, ex_load_rd, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_imm, out_rs1, out_rs2, out_rd,
             out_rs1_used, out_rs2_used, hazard, stall_cycles
   );
endinterface

// File: rtl/decode_stage_controller_immediate_generator.sv
// RISC-V I/S/B/U/J immediate extraction, sign-extended to XLEN.
// Opcodes without an immediate (including unknown ones) produce zero.
module immediate_generator
   import decode_stage_controller_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     i_instr,
   output logic [XLEN-1:0] o_imm
);

   logic [31:0] w_imm32;

   always_comb begin
      w_imm32 = '0;
      case (i_instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR:
            w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
         OP_STORE:
            w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         OP_BRANCH:
            w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                       i_instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            w_imm32 = {i_instr[31:12], 12'b0};
         OP_JAL:
            w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                       i_instr[30:21], 1'b0};
         default:
            w_imm32 = '0;
      endcase
      o_imm = XLEN'(signed'(w_imm32));
   end

endmodule

// File: rtl/decode_stage_controller.sv
// Decode pipeline stage: one-entry instruction register with load-use bubble
// insertion, flush, and a saturating stall counter.
// Optional macro DECODE_SKID_BUFFER_EN adds a skid entry that registers in_ready.
module decode_stage_controller
   import decode_stage_controller_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned STALL_CNT_W = 32
) (
   input logic                       clk,
   input logic                       rst_n,
   decode_stage_controller_if.slave  bus
);

   pipe_entry_t            r_prim;
   pipe_entry_t            w_in_entry;
   logic [STALL_CNT_W-1:0] r_stall_cnt;
   logic [6:0]             w_opcode;
   logic [4:0]             w_rs1;
   logic [4:0]             w_rs2;
   logic [4:0]             w_rd;
   logic                   w_rs1_used;
   logic                   w_rs2_used;
   logic                   w_hazard;
   logic                   w_out_valid;
   logic                   w_drain;
   logic                   w_in_ready;
   logic                   w_xfer;
   logic [XLEN-1:0]        w_imm;

   assign w_opcode   = r_prim.instr[6:0];
   assign w_rs1      = r_prim.instr[19:15];
   assign w_rs2      = r_prim.instr[24:20];
   assign w_rd       = r_prim.instr[11:7];
   assign w_rs1_used = rs1_is_read(w_opcode);
   assign w_rs2_used = rs2_is_read(w_opcode);

   assign w_hazard = r_prim.valid && bus.ex_load_valid && (bus.ex_load_rd != '0) &&
                     ((w_rs1_used && (w_rs1 == bus.ex_load_rd)) ||
                      (w_rs2_used && (w_rs2 == bus.ex_load_rd)));

   assign w_out_valid = r_prim.valid && !w_hazard;
   assign w_drain     = w_out_valid && bus.out_ready;
   assign w_xfer      = bus.in_valid && w_in_ready;
   assign w_in_entry  = '{valid: 1'b1, pc: PIPE_PC_W'(bus.in_pc), instr: bus.in_instr};

`ifdef DECODE_SKID_BUFFER_EN
   pipe_entry_t r_skid;

   assign w_in_ready = !r_skid.valid && !bus.flush;

   // Skid only ever fills while primary is stalled, so a draining primary is
   // refilled from skid first; in_ready is low whenever skid is occupied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prim <= '0;
      end else if (bus.flush) begin
         r_prim.valid <= 1'b0;
      end else if (!r_prim.valid || w_drain) begin
         if (r_skid.valid) begin
            r_prim <= r_skid;
         end else if (w_xfer) begin
            r_prim <= w_in_entry;
         end else begin
            r_prim.valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skid <= '0;
      end else if (bus.flush) begin
         r_skid.valid <= 1'b0;
      end else if (r_prim.valid && !w_drain) begin
         if (w_xfer) begin
            r_skid <= w_in_entry;
         end
      end else begin
         r_skid.valid <= 1'b0;
      end
   end
`else
   assign w_in_ready = !bus.flush && (!r_prim.valid || w_drain);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prim <= '0;
      end else if (bus.flush) begin
         r_prim.valid <= 1'b0;
      end else if (w_xfer) begin
         r_prim <= w_in_entry;
      end else if (w_drain) begin
         r_prim.valid <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_hazard && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   immediate_generator #(
      .XLEN (XLEN)
   ) u_immgen (
      .i_instr (r_prim.instr),
      .o_imm   (w_imm)
   );

   assign bus.in_ready     = w_in_ready;
   assign bus.out_valid    = w_out_valid;
   assign bus.out_pc       = XLEN'(r_prim.pc);
   assign bus.out_instr    = r_prim.instr;
   assign bus.out_imm      = w_imm;
   assign bus.out_rs1      = w_rs1;
   assign bus.out_rs2      = w_rs2;
   assign bus.out_rd       = w_rd;
   assign bus.out_rs1_used = w_rs1_used;
   assign bus.out_rs2_used = w_rs2_used;
   assign bus.hazard       = w_hazard;
   assign bus.stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_decode_stage_controller.sv
// Self-checking bench for decode_stage_controller: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_decode_stage_controller;

   localparam int unsigned XW      = 32;
   localparam int unsigned SW      = 4;
   localparam int unsigned SAT_MAX = (1 << SW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decode_stage_controller_if #(.XLEN(XW), .STALL_CNT_W(SW)) bus ();

   decode_stage_controller #(
      .XLEN        (XW),
      .STALL_CNT_W (SW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   // Reference model: accepted instructions in order; head is what execute sees.
   logic [31:0] q_pc[$];
   logic [31:0] q_ins[$];
   logic [31:0] m_pc    = '0;
   logic [31:0] m_ins   = '0;
   int unsigned m_stall = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_imm(input logic [31:0] w);
      logic [31:0] sx;
      sx = {32{w[31]}};
      case (w[6:0])
         7'h13, 7'h03, 7'h67: return (sx << 12) | (w >> 20);
         7'h23: return (sx << 12) | ((w >> 25) << 5) | ((w >> 7) & 32'h1F);
         7'h63: return (sx << 12) | (((w >> 7) & 32'h1) << 11) |
                       (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
         7'h37, 7'h17: return w & 32'hFFFFF000;
         7'h6F: return (sx << 20) | (((w >> 12) & 32'hFF) << 12) |
                       (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic ref_rs1_used(input logic [31:0] w);
      case (w[6:0])
         7'h37, 7'h17, 7'h6F: return 1'b0;
         default:             return 1'b1;
      endcase
   endfunction

   function automatic logic ref_rs2_used(input logic [31:0] w);
      case (w[6:0])
         7'h33, 7'h23, 7'h63: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [10];
      logic [31:0] w;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
      w        = $urandom;
      w[6:0]   = ops[$urandom_range(0, 9)];
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      return w;
   endfunction

   // Checks all outputs for the current cycle, then advances the model across
   // the next rising edge. Called at posedge+1 with inputs already applied.
   task automatic step();
      logic [31:0] w;
      logic has, r1u, r2u, hz, ov, ir, xfer, drain;
      #1;
      has = (q_pc.size() != 0);
      w   = m_ins;
      r1u = ref_rs1_used(w);
      r2u = ref_rs2_used(w);
      hz  = has && bus.ex_load_valid && (bus.ex_load_rd != 5'd0) &&
            ((r1u && (w[19:15] == bus.ex_load_rd)) || (r2u && (w[24:20] == bus.ex_load_rd)));
      ov    = has && !hz;
      drain = ov && bus.out_ready;
`ifdef DECODE_SKID_BUFFER_EN
      ir = !bus.flush && (q_pc.size() < 2);
`else
      ir = !bus.flush && (!has || drain);
`endif
      xfer = bus.in_valid && ir;
      check("in_ready",     64'(bus.in_ready),     64'(ir));
      check("out_valid",    64'(bus.out_valid),    64'(ov));
      check("hazard",       64'(bus.hazard),       64'(hz));
      check("stall_cycles", 64'(bus.stall_cycles), 64'(m_stall));
      check("out_pc",       64'(bus.out_pc),       64'(m_pc));
      check("out_instr",    64'(bus.out_instr),    64'(w));
      check("out_imm",      64'(bus.out_imm),      64'(ref_imm(w)));
      check("out_rs1",      64'(bus.out_rs1),      64'(w[19:15]));
      check("out_rs2",      64'(bus.out_rs2),      64'(w[24:20]));
      check("out_rd",       64'(bus.out_rd),       64'(w[11:7]));
      check("rs1_used",     64'(bus.out_rs1_used), 64'(r1u));
      check("rs2_used",     64'(bus.out_rs2_used), 64'(r2u));
      @(posedge clk);
      if (bus.flush) begin
         q_pc.delete();
         q_ins.delete();
      end else begin
         if (drain) begin
            void'(q_pc.pop_front());
            void'(q_ins.pop_front());
         end
         if (xfer) begin
            q_pc.push_back(bus.in_pc);
            q_ins.push_back(bus.in_instr);
         end
      end
      if (hz && (m_stall < SAT_MAX)) m_stall++;
      if (q_pc.size() != 0) begin
         m_pc  = q_pc[0];
         m_ins = q_ins[0];
      end
      #1;
   endtask

   task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic lv, input logic [4:0] lrd);
      bus.in_valid      = iv;
      bus.in_pc         = pc;
      bus.in_instr      = ins;
      bus.out_ready     = ordy;
      bus.flush         = fl;
      bus.ex_load_valid = lv;
      bus.ex_load_rd    = lrd;
   endtask

   initial begin
      int unsigned acc;
      logic [31:0] pc;

      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);

      // Reset values while reset is held
      #12;
      check("rst_out_valid", 64'(bus.out_valid),    64'(0));
      check("rst_hazard",    64'(bus.hazard),       64'(0));
      check("rst_stall",     64'(bus.stall_cycles), 64'(0));
      check("rst_out_pc",    64'(bus.out_pc),       64'(0));
      check("rst_out_instr", 64'(bus.out_instr),    64'(0));
      check("rst_out_imm",   64'(bus.out_imm),      64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

      // addi x1,x0,-1 at 0x100
      drive(1'b1, 32'h100, 32'hFFF00093, 1'b0, 1'b0, 1'b0, '0);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      check("addi_out_valid", 64'(bus.out_valid),    64'(1));
      check("addi_imm",       64'(bus.out_imm),      64'(32'hFFFFFFFF));
      check("addi_rd",        64'(bus.out_rd),       64'(1));
      check("addi_rs2_used",  64'(bus.out_rs2_used), 64'(0));
      check("addi_pc",        64'(bus.out_pc),       64'(32'h100));
      step();
      bus.out_ready = 1'b1;
      step();

      // Back-to-back stream of 8
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h200 + 32'(i * 4), 32'h00000013 | (32'(i) << 20), 1'b1, 1'b0, 1'b0, '0);
         step();
         check("stream_valid", 64'(bus.out_valid), 64'(1));
         check("stream_pc",    64'(bus.out_pc),    64'(32'h200 + 32'(i * 4)));
      end
      bus.in_valid = 1'b0;
      step();

      // Load-use hazard on rs2 of add x3,x1,x2
      drive(1'b1, 32'h400, 32'h002081B3, 1'b0, 1'b0, 1'b0, '0);
      step();
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 5'd2);
      #1;
      check("hz_hazard",    64'(bus.hazard),    64'(1));
      check("hz_out_valid", 64'(bus.out_valid), 64'(0));
      step();
      bus.ex_load_valid = 1'b0;
      #1;
      check("hz_stall_cnt", 64'(bus.stall_cycles), 64'(1));
      check("hz_release",   64'(bus.out_valid),    64'(1));
      step();

      // Load to x0 never stalls
      drive(1'b1, 32'h500, 32'h000001B3, 1'b0, 1'b0, 1'b0, '0);
      step();
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 5'd0);
      #1;
      check("x0_hazard",    64'(bus.hazard),    64'(0));
      check("x0_out_valid", 64'(bus.out_valid), 64'(1));
      step();

      // Flush with a full stage and execute stalled
      drive(1'b1, 32'h600, 32'h00100093, 1'b0, 1'b0, 1'b0, '0);
      step();
      drive(1'b1, 32'h604, 32'h00200093, 1'b0, 1'b0, 1'b0, '0);
      step();
      bus.flush = 1'b1;
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      check("flush_out_valid", 64'(bus.out_valid), 64'(0));
      check("flush_in_ready",  64'(bus.in_ready),  64'(1));
      step();

      // Execute stalled for 3 cycles with fetch always offering
      acc = 0;
      pc  = 32'h700;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, pc, 32'h00000013 | (pc << 20), 1'b0, 1'b0, 1'b0, '0);
         #1;
         if (bus.in_valid && bus.in_ready) begin
            acc++;
            pc = pc + 32'd4;
         end
         step();
      end
`ifdef DECODE_SKID_BUFFER_EN
      check("stall_accepts", 64'(acc), 64'(2));
`else
      check("stall_accepts", 64'(acc), 64'(1));
`endif
      check("stall_in_ready", 64'(bus.in_ready), 64'(0));
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
      #1;
      check("release_first", 64'(bus.out_pc), 64'(32'h700));
      step();
`ifdef DECODE_SKID_BUFFER_EN
      check("release_second_pc",    64'(bus.out_pc),    64'(32'h704));
      check("release_second_valid", 64'(bus.out_valid), 64'(1));
`endif
      step();
      step();

      // Long hazard drives the counter into saturation
      drive(1'b1, 32'h800, 32'h00008113, 1'b1, 1'b0, 1'b0, '0);
      step();
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 5'd1);
      for (int i = 0; i < 20; i++) step();
      check("sat_stall", 64'(bus.stall_cycles), 64'(SAT_MAX));
      check("sat_hazard", 64'(bus.hazard), 64'(1));
      bus.ex_load_valid = 1'b0;
      step();

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 9) < 7), $urandom, rand_instr(),
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)));
         step();
      end

      // Asynchronous reset in the middle of a cycle
      drive(1'b1, 32'h900, 32'h00100093, 1'b0, 1'b0, 1'b0, '0);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 64'(bus.out_valid),    64'(0));
      check("async_rst_stall",     64'(bus.stall_cycles), 64'(0));
      check("async_rst_out_pc",    64'(bus.out_pc),       64'(0));
      q_pc.delete();
      q_ins.delete();
      m_pc    = '0;
      m_ins   = '0;
      m_stall = 0;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) begin
         drive(($urandom_range(0, 9) < 7), $urandom, rand_instr(),
               ($urandom_range(0, 9) < 6), 1'b0,
               ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/decode_stage_controller.md
# decode_stage_controller

Instruction-decode pipeline stage controller. It sits between fetch and execute, registers one instruction/PC pair under a valid/ready handshake, and decodes register fields and the sign-extended immediate from the held word. It inserts load-use bubbles toward execute, honours branch/exception flushes, and counts stall cycles for performance monitoring.

## Interface
Parameters:
- XLEN, 32, datapath width for PC, instruction and immediate.
- STALL_CNT_W, 32, width of the hazard stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  fetch offers an instruction.
- in_ready  output  1  stage accepts the instruction this cycle.
- in_pc  input  XLEN  PC of the offered instruction.
- in_instr  input  32  instruction word.
- flush  input  1  discard all held and incoming instructions.
- ex_load_valid  input  1  the instruction in execute is a load.
- ex_load_rd  input  5  destination register of that load.
- out_valid  output  1  decoded instruction is presented to execute.
- out_ready  input  1  execute accepts it.
- out_pc  output  XLEN  held PC.
- out_instr  output  32  held instruction.
- out_imm  output  XLEN  immediate for the held instruction.
- out_rs1, out_rs2, out_rd  output  5 each  bits [19:15], [24:20] and [11:7] of the held instruction.
- out_rs1_used, out_rs2_used  output  1 each  the source operand is architecturally read.
- hazard  output  1  a load-use bubble is being inserted this cycle.
- stall_cycles  output  STALL_CNT_W  saturating count of hazard cycles.

## Operation
- Primary register holds {valid, pc, instr}. A transfer is `in_valid && in_ready`. The register loads on a transfer when it is empty or draining (`out_valid && out_ready`).
- Decode is combinational from the primary register:
  - rs1_used is false for opcodes 0110111, 0010111 and 1101111, and true otherwise.
  - rs2_used is true for opcodes 0110011, 0100011 and 1100011.
  - out_imm is the standard RISC-V I/S/B/U/J immediate. Unknown opcodes give 0.
- hazard = primary valid && ex_load_valid && ex_load_rd != 0 && ((rs1_used && rs1 == ex_load_rd) || (rs2_used && rs2 == ex_load_rd)).
- out_valid = primary valid && !hazard. While hazard is true, the held instruction does not drain. Execute sees a bubble.
- stall_cycles increments by 1 each cycle hazard is true. It saturates at all-ones and never wraps.
- flush has the highest priority:
  - Primary and skid valid clear at the next edge.
  - in_ready = 0 in the flush cycle, so no transfer occurs.
  - out_valid is still driven from current state. A simultaneous out handshake counts as consumed, and the flush still clears the stage.
- Outputs when primary is invalid: out_pc, out_instr and the fields hold their last value. out_valid = 0.

## Timing
- Latency: a transfer at edge N makes the instruction visible with out_valid = 1 after edge N, unless a hazard applies. Throughput is 1 instruction per cycle when out_ready = 1.
- Reset values:
  - All valids 0, out_valid 0, hazard 0, stall_cycles 0.
  - out_pc, out_instr and out_imm are 0. out_imm stays 0 because the instruction register resets to 0.
  - in_ready is 1 from the first cycle after reset deassertion.
- Reset asserted mid-operation clears all state immediately, regardless of the clock.
- A hazard lasts as long as ex_load_* match. Normally this is 1 cycle, but no cycle limit is enforced.

## Configuration
- DECODE_SKID_BUFFER_EN defined:
  - A second {valid, pc, instr} skid register is present.
  - in_ready = !skid_valid && !flush, where skid_valid is registered, so there is no combinational path from out_ready to in_ready.
  - When primary is full and not draining, a transfer lands in skid. When primary drains, skid moves to primary.
  - Ordering is preserved.
- Not defined:
  - No skid register.
  - in_ready = !flush && (!primary_valid || (out_valid && out_ready)), which is combinational from out_ready and hazard.

## Structure
- Shared package: opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG) and a pipeline-entry struct {valid, pc, instr}.
- The sub-module is the existing immediate_generator, instantiated on the primary register's instruction to produce out_imm.

## Test plan
- Reset, then offer addi x1,x0,-1 (0xFFF00093) at pc 0x100 -> next cycle out_valid = 1, out_imm = 0xFFFFFFFF, out_rd = 1, rs2_used = 0.
- Back-to-back stream of 8 instructions with out_ready = 1 -> 8 outputs on 8 consecutive cycles, in order.
- Held add x3,x1,x2 with ex_load_valid = 1 and ex_load_rd = 2 for one cycle -> hazard = 1, out_valid = 0 for that cycle, stall_cycles = 1, then it drains.
- Load to x0 against a held instruction that reads x0 -> hazard = 0.
- Stage full, out_ready = 0, flush = 1 -> next cycle out_valid = 0. With the skid buffer compiled in, skid is also empty and in_ready = 1.
- With the skid buffer: out_ready = 0 for 3 cycles while in_valid = 1 -> exactly one extra instruction is accepted, in_ready drops, and ordering holds on release.
